// File: rtl/mmio_timer_if.sv
// mmio_timer_if: request/response bus between an MMIO initiator and the timer.
// Latency: n/a (wires only). Backpressure: initiator holds valid/addr/wmask/wdata until ready.
// Signals: valid, addr[3:0], wmask[3:0] (0 = read), wdata[31:0] -> ; <- ready (1-cycle pulse), rdata[31:0].
interface mmio_timer_if;
  logic        valid;
  logic        ready;
  logic [3:0]  addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output valid, addr, wmask, wdata, input ready, rdata);
  modport slave  (input valid, addr, wmask, wdata, output ready, rdata);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: 64-bit free-running time counter driven by a fractional accumulator, with a 64-bit compare.
// Latency: ready and rdata one cycle after valid. Backpressure: none, requests seen while ready=1 are ignored.
// Ports: i_clk, i_rst (async, active-high), bus (mmio_timer_if.slave), o_irq (level).
// Register map: 0x0 TIME_LO, 0x4 TIME_HI (shadow), 0x8 CMP_LO, 0xC CMP_HI.
// Build option: define MMIO_TIMER_IRQ_EN to include the compare/irq logic; otherwise irq=0 and CMP reads 0.
module mmio_timer #(
  parameter int unsigned STEP  = 336,
  parameter int unsigned ACC_W = 25
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mmio_timer_if.slave bus,
  output logic        o_irq
);

  logic [ACC_W-1:0] r_acc;
  logic [63:0]      r_time;
  logic [31:0]      r_shadow;
  logic             r_ready;
  logic [31:0]      r_rdata;

  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_tick;
  logic             w_req;
  logic             w_wr;
  logic             w_rd;
  logic [1:0]       w_word;
  logic [31:0]      w_bmask;
  logic [63:0]      w_time_inc;
  logic [63:0]      w_time_nxt;
  logic [31:0]      w_shadow_nxt;
  logic [31:0]      w_rdata_nxt;
  logic [63:0]      w_cmp_rd;
  logic             w_unused_addr;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  // Bits [1:0] of addr are don't-care: registers are word addressed.
  assign w_unused_addr = ^bus.addr[1:0];

  // Carry out of the low ACC_W-1 bits lands in the top bit and is the tick.
  assign w_acc_nxt  = {1'b0, r_acc[ACC_W-2:0]} + ACC_W'(STEP);
  assign w_tick     = r_acc[ACC_W-1];
  assign w_time_inc = r_time + {63'd0, w_tick};

  // A request is only taken when ready is low, giving the 0,1,0,1 pattern.
  assign w_req  = bus.valid & ~r_ready;
  assign w_wr   = w_req & (|bus.wmask);
  assign w_rd   = w_req & ~(|bus.wmask);
  assign w_word = bus.addr[3:2];
  assign w_bmask = {{8{bus.wmask[3]}}, {8{bus.wmask[2]}},
                    {8{bus.wmask[1]}}, {8{bus.wmask[0]}}};

  // Time writes merge onto the incremented value, so unwritten bytes still count.
  always_comb begin
    w_time_nxt   = w_time_inc;
    w_shadow_nxt = r_shadow;
    w_rdata_nxt  = 32'd0;
    if (w_wr) begin
      case (w_word)
        2'd0: w_time_nxt[31:0] = f_merge(w_time_inc[31:0], bus.wdata, w_bmask);
        2'd1: begin
          w_time_nxt[63:32] = f_merge(w_time_inc[63:32], bus.wdata, w_bmask);
          w_shadow_nxt      = f_merge(w_time_inc[63:32], bus.wdata, w_bmask);
        end
        default: ;
      endcase
    end
    if (w_rd) begin
      case (w_word)
        2'd0: begin
          w_rdata_nxt  = r_time[31:0];
          // Capture the high half with the low half so a LO/HI pair is coherent.
          w_shadow_nxt = r_time[63:32];
        end
        2'd1:    w_rdata_nxt = r_shadow;
        2'd2:    w_rdata_nxt = w_cmp_rd[31:0];
        default: w_rdata_nxt = w_cmp_rd[63:32];
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_time   <= 64'd0;
      r_shadow <= 32'd0;
      r_ready  <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_acc    <= w_acc_nxt;
      r_time   <= w_time_nxt;
      r_shadow <= w_shadow_nxt;
      r_ready  <= w_req;
      r_rdata  <= w_rdata_nxt;
    end
  end

  assign bus.ready = r_ready;
  assign bus.rdata = r_rdata;

`ifdef MMIO_TIMER_IRQ_EN
  logic [63:0] r_cmp;
  logic [63:0] w_cmp_nxt;
  logic        r_irq;

  always_comb begin
    w_cmp_nxt = r_cmp;
    if (w_wr && (w_word == 2'd2)) w_cmp_nxt[31:0]  = f_merge(r_cmp[31:0],  bus.wdata, w_bmask);
    if (w_wr && (w_word == 2'd3)) w_cmp_nxt[63:32] = f_merge(r_cmp[63:32], bus.wdata, w_bmask);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_irq <= 1'b0;
    end else begin
      r_cmp <= w_cmp_nxt;
      r_irq <= (r_time >= r_cmp);
    end
  end

  assign w_cmp_rd = r_cmp;
  assign o_irq    = r_irq;
`else
  // Compare logic absent: CMP writes complete but are dropped, reads return 0.
  assign w_cmp_rd = 64'd0;
  assign o_irq    = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed self-checking bench for mmio_timer.
// The DUT uses STEP = 2^(ACC_W-1): acc[ACC_W-2:0] is always 0 after the first edge,
// so from the second edge after reset release time increments on every clock.
module tb_mmio_timer;
  localparam int unsigned ACC_W = 25;
  localparam int unsigned STEP  = 32'd16777216;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic o_irq;
  int   n_checks = 0;
  int   n_fail   = 0;

  mmio_timer_if bif ();

  mmio_timer #(.STEP(STEP), .ACC_W(ACC_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bif),
    .o_irq (o_irq)
  );

  always #5 i_clk = ~i_clk;

`ifdef MMIO_TIMER_IRQ_EN
  localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] CMP_RST = 32'h0;
`endif

  // One bus request, started just after a clock edge. Returns ready/rdata from the
  // commit edge and ready one edge later. Ends just after the falling-ready edge.
  task automatic bus_op(input logic [3:0] a, input logic [3:0] m, input logic [31:0] d,
                        output logic rdy, output logic [31:0] rd, output logic rdy_after);
    bif.valid = 1'b1;
    bif.addr  = a;
    bif.wmask = m;
    bif.wdata = d;
    @(posedge i_clk); #1;
    rdy = bif.ready;
    rd  = bif.rdata;
    bif.valid = 1'b0;
    bif.wmask = 4'h0;
    @(posedge i_clk); #1;
    rdy_after = bif.ready;
  endtask

  task automatic test_reset();
    logic r, ra;
    logic [31:0] d;
    i_rst = 1'b1;
    bif.valid = 1'b0; bif.addr = 4'h0; bif.wmask = 4'h0; bif.wdata = 32'h0;
    repeat (3) @(posedge i_clk);
    #1;
    n_checks++; if (bif.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", bif.ready); end
    n_checks++; if (bif.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bif.rdata); end
    n_checks++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=0", o_irq); end
    i_rst = 1'b0;
    bus_op(4'hC, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL reset_cmphi_ready got=%b exp=1", r); end
    n_checks++; if (d !== CMP_RST) begin n_fail++; $display("FAIL reset_cmphi got=%h exp=%h", d, CMP_RST); end
    n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL reset_ready_fall got=%b exp=0", ra); end
  endtask

  task automatic test_count();
    logic r, ra;
    logic [31:0] d;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    // Commit at first edge after release: time still 0.
    bus_op(4'h0, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL count_first got=%0d exp=0", d); end
    repeat (9) @(posedge i_clk);
    #1;
    // Now after the 11th edge: ten ticks have been counted.
    bus_op(4'h0, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'd10) begin n_fail++; $display("FAIL count_ten got=%0d exp=10", d); end
  endtask

  task automatic test_coherent();
    logic r, ra;
    logic [31:0] d;
    bus_op(4'h4, 4'hF, 32'h0, r, d, ra);            // HI=0
    n_checks++; if (r !== 1'b1 || ra !== 1'b0) begin n_fail++; $display("FAIL coh_wr_ready got=%b%b exp=10", r, ra); end
    bus_op(4'h0, 4'hF, 32'hFFFF_FFFE, r, d, ra);    // LO=FFFFFFFE, next edge FFFFFFFF
    bus_op(4'h0, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL coh_lo1 got=%h exp=ffffffff", d); end
    bus_op(4'h4, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL coh_hi1 got=%h exp=0", d); end
    bus_op(4'h0, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL coh_lo2 got=%h exp=3", d); end
    bus_op(4'h4, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL coh_hi2 got=%h exp=1", d); end
  endtask

  task automatic test_mask();
    logic r, ra;
    logic [31:0] d;
    bus_op(4'h4, 4'hF, 32'h0, r, d, ra);
    bus_op(4'h0, 4'hF, 32'h1122_3344, r, d, ra);
    bus_op(4'h1, 4'b0010, 32'h0000_AB00, r, d, ra);  // addr[1:0] ignored
    bus_op(4'h0, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'h1122_AB47) begin n_fail++; $display("FAIL mask_lo got=%h exp=1122ab47", d); end
    bus_op(4'h4, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mask_hi got=%h exp=0", d); end
  endtask

  task automatic test_back_to_back();
    logic r, ra;
    logic [31:0] d;
    logic        exp_rdy [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_dat [4] = '{32'h101, 32'h0, 32'h103, 32'h0};
    bus_op(4'h0, 4'hF, 32'h100, r, d, ra);
    bif.valid = 1'b1; bif.addr = 4'h0; bif.wmask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      n_checks++; if (bif.ready !== exp_rdy[i]) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, bif.ready, exp_rdy[i]); end
      n_checks++; if (bif.rdata !== exp_dat[i]) begin n_fail++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", i, bif.rdata, exp_dat[i]); end
    end
    bif.valid = 1'b0;
    @(posedge i_clk); #1;
    n_checks++; if (bif.ready !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", bif.ready); end
  endtask

  task automatic test_irq();
    logic r, ra;
    logic [31:0] d;
`ifdef MMIO_TIMER_IRQ_EN
    bus_op(4'h4, 4'hF, 32'h0, r, d, ra);
    bus_op(4'h0, 4'hF, 32'h0, r, d, ra);
    bus_op(4'hC, 4'hF, 32'h0, r, d, ra);
    bus_op(4'h8, 4'hF, 32'd5, r, d, ra);   // time is 5 after this op
    n_checks++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_before got=%b exp=0", o_irq); end
    @(posedge i_clk); #1;
    n_checks++; if (o_irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b exp=1", o_irq); end
    bus_op(4'h8, 4'hF, 32'd106, r, d, ra); // time was 6 when issued
    n_checks++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall got=%b exp=0", o_irq); end
    bus_op(4'h8, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'd106) begin n_fail++; $display("FAIL irq_cmplo got=%0d exp=106", d); end
`else
    bus_op(4'h8, 4'hF, 32'd5, r, d, ra);
    n_checks++; if (r !== 1'b1) begin n_fail++; $display("FAIL cmp_wr_ready got=%b exp=1", r); end
    bus_op(4'h8, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL cmp_read got=%h exp=0", d); end
    repeat (8) @(posedge i_clk);
    #1;
    n_checks++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied got=%b exp=0", o_irq); end
`endif
  endtask

  task automatic test_reset_abort();
    logic r, ra;
    logic [31:0] d;
    bif.valid = 1'b1; bif.addr = 4'h8; bif.wmask = 4'hF; bif.wdata = 32'h12;
    #2;
    i_rst = 1'b1;
    #1;
    n_checks++; if (bif.ready !== 1'b0 || bif.rdata !== 32'h0) begin n_fail++; $display("FAIL abort_in_reset got=%b/%h exp=0/0", bif.ready, bif.rdata); end
    bif.valid = 1'b0; bif.wmask = 4'h0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    n_checks++; if (bif.ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got=%b exp=0", bif.ready); end
    bus_op(4'h0, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL abort_time got=%h exp=0", d); end
    bus_op(4'h8, 4'h0, 32'h0, r, d, ra);
    n_checks++; if (d !== CMP_RST) begin n_fail++; $display("FAIL abort_cmp got=%h exp=%h", d, CMP_RST); end
  endtask

  initial begin
    test_reset();
    test_count();
    test_coherent();
    test_mask();
    test_back_to_back();
    test_irq();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
